milano_id_stage: RTL and testbench
==================================

# milano_id_stage

Instruction decode stage of the milano RV32I core. Sits between fetch and execute:
- Accepts one 32-bit instruction plus its PC per valid/ready handshake.
- Decodes it into ALU operation, register addresses, immediate, operand selects and memory/branch controls.
- Holds the result in a single registered pipeline slot that feeds the execute stage (ALU).

## Interface
Parameters:
- none (RV32I, XLEN fixed at 32)

Ports:
- clk_i  in  1  core clock; all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- flush_i  in  1  discard held instruction and block capture this cycle
- instr_valid_i  in  1  fetch presents an instruction
- instr_i  in  32  instruction word
- pc_i  in  32  PC of instr_i
- instr_ready_o  out  1  stage can accept this cycle
- id_valid_o  out  1  decoded slot valid
- ex_ready_i  in  1  execute consumes slot this cycle
- pc_o  out  32  PC of held instruction
- alu_opt_o  out  alu_opt_e  ALU operation
- op_a_sel_o  out  op_a_sel_e  ALU operand A: OPA_RS1, OPA_PC, OPA_ZERO
- op_b_sel_o  out  op_b_sel_e  ALU operand B: OPB_RS2, OPB_IMM
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each  register addresses
- rd_we_o  out  1  register write enable
- imm_o  out  32  sign-extended immediate
- mem_req_o, mem_we_o  out  1 each  load/store request, store flag
- mem_size_o  out  2  0 byte, 1 half, 2 word
- mem_unsigned_o  out  1  LBU/LHU
- branch_o, jump_o  out  1 each  conditional branch; JAL/JALR
- branch_cond_o  out  3  funct3 of branch
- illegal_o  out  1  illegal instruction flag

## Operation
- instr_ready_o = !id_valid_o || ex_ready_i (combinational).
- Capture when instr_valid_i && instr_ready_o && !flush_i: decode instr_i, register all outputs, set id_valid_o.
- Consume without new capture: clear id_valid_o; other outputs hold their values.
- flush_i has priority over capture and hold: id_valid_o cleared next cycle.
- Decode by opcode_e; imm by format I/S/B/U/J:
  - OP: funct3/funct7 select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; A=RS1, B=RS2.
  - OP_IMM: same, but SUB is not selectable; SRAI selected by funct7=0x20; B=IMM.
  - LUI: ALU_ADD, A=ZERO, B=IMM.
  - AUIPC: ALU_ADD, A=PC, B=IMM.
  - LOAD: ALU_ADD, A=RS1, B=IMM, mem_req=1.
  - STORE: ALU_ADD, A=RS1, B=IMM, mem_req=1, mem_we=1, rd_we=0.
  - BRANCH: BEQ/BNE use ALU_SUB; BLT/BGE use ALU_SLT; BLTU/BGEU use ALU_SLTU; rd_we=0.
  - JAL: ALU_ADD, A=PC, B=IMM, jump=1.
  - JALR: ALU_ADD, A=RS1, B=IMM, jump=1.
  - MISC_MEM (FENCE): NOP, i.e. ALU_NONE with all controls 0.
  - SYSTEM: ECALL/EBREAK are flagged illegal_o=1; other SYSTEM encodings are also illegal.
- rd_we_o forced 0 when rd=0.
- Illegal instruction:
  - Triggers: unknown opcode; OP funct7 not in {0x00, 0x20}; funct7=0x20 with funct3 not 0 or 5; bad shift funct7; JALR funct3≠0; branch funct3 2/3; load funct3 3/6/7; store funct3>2.
  - Response: illegal_o=1, alu_opt_o=ALU_NONE, rd_we/mem_req/branch/jump=0; still presented with id_valid_o=1.

## Timing
- Latency: 1 cycle from capture to id_valid_o.
- Full throughput: back-to-back accepts while ex_ready_i=1.
- Reset values: id_valid_o=0; all data/control outputs 0; alu_opt_o=ALU_NONE; op selects = value 0 encodings.
- Backpressure: id_valid_o && !ex_ready_i holds all outputs stable and keeps instr_ready_o=0.
- Simultaneous consume and capture: new instruction replaces old in the same edge, no bubble.
- Reset mid-operation clears the slot immediately (asynchronous); the instruction is lost.

## Structure
- Add to milano_pkg: op_a_sel_e (OPA_RS1=0, OPA_PC, OPA_ZERO), op_b_sel_e (OPB_RS2=0, OPB_IMM), mem_size_e, imm-format enum.
- Natural sub-module: milano_decoder, purely combinational (instr_i → decoded controls). milano_id_stage holds handshake and pipeline register only.

## Test plan
- Reset, then 0x002081B3 (add x3,x1,x2) → next cycle ALU_ADD, rs1=1, rs2=2, rd=3, rd_we=1, OPA_RS1/OPB_RS2.
- 0x402081B3 (sub), then 0x123452B7 (lui x5) back-to-back with ex_ready_i=1 → ALU_SUB, then ALU_ADD, OPA_ZERO, imm=0x12345000, rd=5; no bubble.
- 0xFFC3A303 (lw x6,-4(x7)) with ex_ready_i=0 for 3 cycles → imm=0xFFFFFFFC, mem_size=2, mem_req=1; outputs stable and instr_ready_o=0 until ex_ready_i rises.
- 0x00000000 → illegal_o=1, ALU_NONE, rd_we=0, mem_req=0, id_valid_o=1.
- flush_i asserted with instr_valid_i=1 and a held slot → id_valid_o=0 next cycle, new instruction not captured.
- rst_ni dropped mid-stall → id_valid_o=0 and alu_opt_o=ALU_NONE asynchronously; first instruction after release decodes normally.

Source files
------------

// File: rtl/milano_pkg.sv
// Shared types for the milano RV32I core: opcodes, ALU operations, operand
// selects, memory sizes, immediate formats and the decoded control bundle.
package milano_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'h03,
    OPC_MISC_MEM = 7'h0F,
    OPC_OP_IMM   = 7'h13,
    OPC_AUIPC    = 7'h17,
    OPC_STORE    = 7'h23,
    OPC_OP       = 7'h33,
    OPC_LUI      = 7'h37,
    OPC_BRANCH   = 7'h63,
    OPC_JALR     = 7'h67,
    OPC_JAL      = 7'h6F,
    OPC_SYSTEM   = 7'h73
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SLTU = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_OR   = 4'd9,
    ALU_AND  = 4'd10
  } alu_opt_e;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'd0,
    OPA_PC   = 2'd1,
    OPA_ZERO = 2'd2
  } op_a_sel_e;

  typedef enum logic {
    OPB_RS2 = 1'b0,
    OPB_IMM = 1'b1
  } op_b_sel_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    alu_opt_e    alu_opt;
    op_a_sel_e   op_a_sel;
    op_b_sel_e   op_b_sel;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [31:0] imm;
    logic        mem_req;
    logic        mem_we;
    mem_size_e   mem_size;
    logic        mem_unsigned;
    logic        branch;
    logic        jump;
    logic [2:0]  branch_cond;
    logic        illegal;
  } decode_t;

  localparam decode_t DECODE_RESET = '{
    alu_opt:      ALU_NONE,
    op_a_sel:     OPA_RS1,
    op_b_sel:     OPB_RS2,
    rs1_addr:     5'd0,
    rs2_addr:     5'd0,
    rd_addr:      5'd0,
    rd_we:        1'b0,
    imm:          32'd0,
    mem_req:      1'b0,
    mem_we:       1'b0,
    mem_size:     MEM_BYTE,
    mem_unsigned: 1'b0,
    branch:       1'b0,
    jump:         1'b0,
    branch_cond:  3'd0,
    illegal:      1'b0
  };

  // funct3 → ALU op for OP/OP_IMM; alt picks SUB/SRA where funct7[5] allows it.
  function automatic alu_opt_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_opt_e op;
    case (funct3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] imm_extract(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'd0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/milano_decoder.sv
// Purely combinational RV32I decoder: instruction word to control bundle.
module milano_decoder
  import milano_pkg::*;
(
  input  logic [31:0] instr_i,
  output decode_t     dec_o
);

  opcode_e    opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  imm_fmt_e   imm_fmt;
  logic       illegal;
  decode_t    dec;

  assign opcode = opcode_e'(instr_i[6:0]);
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    dec          = DECODE_RESET;
    dec.rs1_addr = instr_i[19:15];
    dec.rs2_addr = instr_i[24:20];
    dec.rd_addr  = instr_i[11:7];
    imm_fmt      = IMM_NONE;
    illegal      = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec.rd_we   = 1'b1;
        dec.alu_opt = alu_from_funct3(funct3, funct7[5]);
        if (!(funct7 == 7'h00 ||
              (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)))) begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        imm_fmt      = IMM_I;
        dec.op_b_sel = OPB_IMM;
        dec.rd_we    = 1'b1;
        // Only the right-shift form can select the arithmetic variant.
        dec.alu_opt  = alu_from_funct3(funct3, (funct3 == 3'd5) && funct7[5]);
        if (funct3 == 3'd1 && funct7 != 7'h00) begin
          illegal = 1'b1;
        end
        if (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20) begin
          illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        imm_fmt      = IMM_U;
        dec.alu_opt  = ALU_ADD;
        dec.op_a_sel = OPA_ZERO;
        dec.op_b_sel = OPB_IMM;
        dec.rd_we    = 1'b1;
      end
      OPC_AUIPC: begin
        imm_fmt      = IMM_U;
        dec.alu_opt  = ALU_ADD;
        dec.op_a_sel = OPA_PC;
        dec.op_b_sel = OPB_IMM;
        dec.rd_we    = 1'b1;
      end
      OPC_LOAD: begin
        imm_fmt          = IMM_I;
        dec.alu_opt      = ALU_ADD;
        dec.op_b_sel     = OPB_IMM;
        dec.rd_we        = 1'b1;
        dec.mem_req      = 1'b1;
        dec.mem_size     = mem_size_e'(funct3[1:0]);
        dec.mem_unsigned = funct3[2];
        if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        imm_fmt      = IMM_S;
        dec.alu_opt  = ALU_ADD;
        dec.op_b_sel = OPB_IMM;
        dec.mem_req  = 1'b1;
        dec.mem_we   = 1'b1;
        dec.mem_size = mem_size_e'(funct3[1:0]);
        if (funct3 > 3'd2) begin
          illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        imm_fmt         = IMM_B;
        dec.branch      = 1'b1;
        dec.branch_cond = funct3;
        case (funct3)
          3'd0, 3'd1: dec.alu_opt = ALU_SUB;
          3'd4, 3'd5: dec.alu_opt = ALU_SLT;
          3'd6, 3'd7: dec.alu_opt = ALU_SLTU;
          default:    illegal     = 1'b1;
        endcase
      end
      OPC_JAL: begin
        imm_fmt      = IMM_J;
        dec.alu_opt  = ALU_ADD;
        dec.op_a_sel = OPA_PC;
        dec.op_b_sel = OPB_IMM;
        dec.rd_we    = 1'b1;
        dec.jump     = 1'b1;
      end
      OPC_JALR: begin
        imm_fmt      = IMM_I;
        dec.alu_opt  = ALU_ADD;
        dec.op_b_sel = OPB_IMM;
        dec.rd_we    = 1'b1;
        dec.jump     = 1'b1;
        if (funct3 != 3'd0) begin
          illegal = 1'b1;
        end
      end
      OPC_MISC_MEM: begin
        // FENCE is a no-op on this in-order core.
      end
      default: begin
        // SYSTEM (ECALL/EBREAK/CSR) is not supported and traps like any unknown opcode.
        illegal = 1'b1;
      end
    endcase

    dec.imm = imm_extract(instr_i, imm_fmt);

    // Illegal instructions keep their register fields and immediate, but
    // must never have side effects downstream.
    if (illegal) begin
      dec.alu_opt      = ALU_NONE;
      dec.op_a_sel     = OPA_RS1;
      dec.op_b_sel     = OPB_RS2;
      dec.rd_we        = 1'b0;
      dec.mem_req      = 1'b0;
      dec.mem_we       = 1'b0;
      dec.mem_size     = MEM_BYTE;
      dec.mem_unsigned = 1'b0;
      dec.branch       = 1'b0;
      dec.jump         = 1'b0;
      dec.branch_cond  = 3'd0;
    end
    dec.illegal = illegal;

    if (dec.rd_addr == 5'd0) begin
      dec.rd_we = 1'b0;
    end
  end

  assign dec_o = dec;

endmodule

// File: rtl/milano_id_stage.sv
// Decode stage: valid/ready handshake from fetch, one registered slot feeding execute.
module milano_id_stage
  import milano_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        instr_ready_o,
  output logic        id_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] pc_o,
  output alu_opt_e    alu_opt_o,
  output op_a_sel_e   op_a_sel_o,
  output op_b_sel_e   op_b_sel_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_we_o,
  output logic [31:0] imm_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [1:0]  mem_size_o,
  output logic        mem_unsigned_o,
  output logic        branch_o,
  output logic        jump_o,
  output logic [2:0]  branch_cond_o,
  output logic        illegal_o
);

  decode_t     dec_d, dec_q;
  logic [31:0] pc_q;
  logic        valid_d, valid_q;
  logic        capture;

  milano_decoder u_decoder (
    .instr_i (instr_i),
    .dec_o   (dec_d)
  );

  assign instr_ready_o = !valid_q || ex_ready_i;
  assign capture       = instr_valid_i && instr_ready_o && !flush_i;

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
    end else if (ex_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload only moves on capture so consumed or flushed slots keep their last values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_q <= DECODE_RESET;
      pc_q  <= 32'd0;
    end else if (capture) begin
      dec_q <= dec_d;
      pc_q  <= pc_i;
    end
  end

  assign id_valid_o     = valid_q;
  assign pc_o           = pc_q;
  assign alu_opt_o      = dec_q.alu_opt;
  assign op_a_sel_o     = dec_q.op_a_sel;
  assign op_b_sel_o     = dec_q.op_b_sel;
  assign rs1_addr_o     = dec_q.rs1_addr;
  assign rs2_addr_o     = dec_q.rs2_addr;
  assign rd_addr_o      = dec_q.rd_addr;
  assign rd_we_o        = dec_q.rd_we;
  assign imm_o          = dec_q.imm;
  assign mem_req_o      = dec_q.mem_req;
  assign mem_we_o       = dec_q.mem_we;
  assign mem_size_o     = dec_q.mem_size;
  assign mem_unsigned_o = dec_q.mem_unsigned;
  assign branch_o       = dec_q.branch;
  assign jump_o         = dec_q.jump;
  assign branch_cond_o  = dec_q.branch_cond;
  assign illegal_o      = dec_q.illegal;

endmodule

// File: tb/tb_milano_id_stage.sv
// Bench for milano_id_stage: directed scenarios plus a random run against a
// slot-level reference model.
module tb_milano_id_stage;
  import milano_pkg::*;

  logic        clk, rst_n, flush, instr_valid, ex_ready;
  logic [31:0] instr, pc;
  logic        instr_ready, id_valid;
  logic [31:0] pc_out, imm;
  alu_opt_e    alu_opt;
  op_a_sel_e   op_a_sel;
  op_b_sel_e   op_b_sel;
  logic [4:0]  rs1, rs2, rd;
  logic        rd_we, mem_req, mem_we, mem_uns, branch, jump, illegal;
  logic [1:0]  mem_size;
  logic [2:0]  bcond;

  int total = 0;
  int bad   = 0;

  milano_id_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .instr_valid_i(instr_valid),
    .instr_i(instr), .pc_i(pc), .instr_ready_o(instr_ready), .id_valid_o(id_valid),
    .ex_ready_i(ex_ready), .pc_o(pc_out), .alu_opt_o(alu_opt), .op_a_sel_o(op_a_sel),
    .op_b_sel_o(op_b_sel), .rs1_addr_o(rs1), .rs2_addr_o(rs2), .rd_addr_o(rd),
    .rd_we_o(rd_we), .imm_o(imm), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_size_o(mem_size), .mem_unsigned_o(mem_uns), .branch_o(branch), .jump_o(jump),
    .branch_cond_o(bcond), .illegal_o(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    alu_opt_e    alu;
    op_a_sel_e   a;
    op_b_sel_e   b;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we;
    logic [31:0] imm;
    logic        mem_req, mem_we;
    logic [1:0]  mem_size;
    logic        mem_uns, branch, jump;
    logic [2:0]  bcond;
    logic        illegal;
  } ref_t;

  ref_t        m;
  logic        m_valid;
  logic [31:0] m_pc;

  function automatic ref_t ref_zero();
    ref_t r;
    r = '0;
    r.alu = ALU_NONE;
    r.a   = OPA_RS1;
    r.b   = OPB_RS2;
    return r;
  endfunction

  function automatic alu_opt_e arith(input int f3, input bit alt);
    case (f3)
      0: return alt ? ALU_SUB : ALU_ADD;
      1: return ALU_SLL;
      2: return ALU_SLT;
      3: return ALU_SLTU;
      4: return ALU_XOR;
      5: return alt ? ALU_SRA : ALU_SRL;
      6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Reference decoder built from the ISA tables with integer arithmetic.
  function automatic ref_t ref_decode(input logic [31:0] ins);
    ref_t r;
    int   opc, f3, f7;
    bit   bad_enc;
    logic signed [11:0] i12, s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    opc = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    r = ref_zero();
    r.rs1 = ins[19:15];
    r.rs2 = ins[24:20];
    r.rd  = ins[11:7];
    bad_enc = 1'b0;
    case (opc)
      'h33: begin
        r.alu = arith(f3, f7 == 'h20); r.rd_we = 1;
        bad_enc = !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
      end
      'h13: begin
        r.imm = 32'(int'(i12)); r.b = OPB_IMM; r.rd_we = 1;
        r.alu = arith(f3, f3 == 5 && f7 == 'h20);
        if (f3 == 1) bad_enc = (f7 != 0);
        if (f3 == 5) bad_enc = !(f7 == 0 || f7 == 'h20);
      end
      'h37: begin r.imm = ins & 32'hFFFF_F000; r.alu = ALU_ADD; r.a = OPA_ZERO; r.b = OPB_IMM; r.rd_we = 1; end
      'h17: begin r.imm = ins & 32'hFFFF_F000; r.alu = ALU_ADD; r.a = OPA_PC; r.b = OPB_IMM; r.rd_we = 1; end
      'h03: begin
        r.imm = 32'(int'(i12)); r.alu = ALU_ADD; r.b = OPB_IMM; r.rd_we = 1; r.mem_req = 1;
        r.mem_size = 2'(f3 % 4); r.mem_uns = (f3 >= 4);
        bad_enc = (f3 == 3 || f3 == 6 || f3 == 7);
      end
      'h23: begin
        r.imm = 32'(int'(s12)); r.alu = ALU_ADD; r.b = OPB_IMM; r.mem_req = 1; r.mem_we = 1;
        r.mem_size = 2'(f3 % 4); bad_enc = (f3 > 2);
      end
      'h63: begin
        r.imm = 32'(int'(b13)); r.branch = 1; r.bcond = 3'(f3);
        if (f3 < 2) r.alu = ALU_SUB;
        else if (f3 < 4) bad_enc = 1;
        else if (f3 < 6) r.alu = ALU_SLT;
        else r.alu = ALU_SLTU;
      end
      'h6F: begin r.imm = 32'(int'(j21)); r.alu = ALU_ADD; r.a = OPA_PC; r.b = OPB_IMM; r.rd_we = 1; r.jump = 1; end
      'h67: begin
        r.imm = 32'(int'(i12)); r.alu = ALU_ADD; r.b = OPB_IMM; r.rd_we = 1; r.jump = 1;
        bad_enc = (f3 != 0);
      end
      'h0F: ;
      default: bad_enc = 1;
    endcase
    if (bad_enc) begin
      r.alu = ALU_NONE; r.a = OPA_RS1; r.b = OPB_RS2; r.rd_we = 0; r.mem_req = 0;
      r.mem_we = 0; r.mem_size = 0; r.mem_uns = 0; r.branch = 0; r.jump = 0; r.bcond = 0;
      r.illegal = 1;
    end
    if (r.rd == 0) r.rd_we = 0;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = 32'd0;
    m       = ref_zero();
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] p,
                       input bit exr, input bit fl);
    @(negedge clk);
    instr_valid = v; instr = ins; pc = p; ex_ready = exr; flush = fl;
  endtask

  // Advances one clock and applies the slot rules to the model.
  task automatic tick();
    bit rdy, cap;
    rdy = !m_valid || ex_ready;
    cap = instr_valid && rdy && !flush;
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (cap) begin m_valid = 1'b1; m = ref_decode(instr); m_pc = pc; end
    else if (ex_ready) m_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", id_valid); end
    total++; if (alu_opt !== ALU_NONE) begin bad++; $display("FAIL reset_alu got=%0d exp=%0d", alu_opt, ALU_NONE); end
    total++; if ({pc_out, imm, rd_we, mem_req, illegal, op_a_sel, op_b_sel} !== '0) begin
      bad++; $display("FAIL reset_fields got pc=%h imm=%h ctl=%b exp all zero", pc_out, imm,
                      {rd_we, mem_req, illegal, op_a_sel, op_b_sel});
    end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", instr_ready); end
  endtask

  task automatic test_add();
    drive(1, 32'h0020_81B3, 32'h0000_0100, 1, 0);
    tick();
    total++; if (id_valid !== 1'b1 || alu_opt !== ALU_ADD) begin
      bad++; $display("FAIL add_alu got v=%0b alu=%0d exp v=1 alu=%0d", id_valid, alu_opt, ALU_ADD);
    end
    total++; if ({rs1, rs2, rd, rd_we} !== {5'd1, 5'd2, 5'd3, 1'b1}) begin
      bad++; $display("FAIL add_regs got rs1=%0d rs2=%0d rd=%0d we=%0b exp 1 2 3 1", rs1, rs2, rd, rd_we);
    end
    total++; if (op_a_sel !== OPA_RS1 || op_b_sel !== OPB_RS2 || pc_out !== 32'h100) begin
      bad++; $display("FAIL add_sel got a=%0d b=%0d pc=%h exp 0 0 00000100", op_a_sel, op_b_sel, pc_out);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 32'h4020_81B3, 32'h0000_0104, 1, 0);
    tick();
    total++; if (id_valid !== 1'b1 || alu_opt !== ALU_SUB) begin
      bad++; $display("FAIL b2b_sub got v=%0b alu=%0d exp v=1 alu=%0d", id_valid, alu_opt, ALU_SUB);
    end
    drive(1, 32'h1234_52B7, 32'h0000_0108, 1, 0);
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b exp=1", instr_ready); end
    tick();
    total++; if (id_valid !== 1'b1 || alu_opt !== ALU_ADD || op_a_sel !== OPA_ZERO) begin
      bad++; $display("FAIL b2b_lui got v=%0b alu=%0d a=%0d exp v=1 alu=%0d a=%0d",
                      id_valid, alu_opt, op_a_sel, ALU_ADD, OPA_ZERO);
    end
    total++; if (imm !== 32'h1234_5000 || rd !== 5'd5 || pc_out !== 32'h108) begin
      bad++; $display("FAIL b2b_lui_imm got imm=%h rd=%0d pc=%h exp 12345000 5 00000108", imm, rd, pc_out);
    end
  endtask

  task automatic test_stall();
    drive(0, 32'h0, 32'h0, 1, 0);
    tick();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%0b exp=0", id_valid); end
    drive(1, 32'hFFC3_A303, 32'h0000_0200, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0020_81B3, 32'h0000_0204, 0, 0);
      #1;
      total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%0b exp=0", i, instr_ready); end
      tick();
      total++; if ({id_valid, imm, mem_size, mem_req, rd, rs1, alu_opt, pc_out} !==
                   {1'b1, 32'hFFFF_FFFC, 2'd2, 1'b1, 5'd6, 5'd7, ALU_ADD, 32'h200}) begin
        bad++; $display("FAIL stall_hold[%0d] got v=%0b imm=%h sz=%0d req=%0b rd=%0d rs1=%0d alu=%0d pc=%h exp 1 fffffffc 2 1 6 7 %0d 00000200",
                        i, id_valid, imm, mem_size, mem_req, rd, rs1, alu_opt, pc_out, ALU_ADD);
      end
    end
    drive(0, 32'h0, 32'h0, 1, 0);
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%0b exp=1", instr_ready); end
    tick();
    total++; if (id_valid !== 1'b0 || imm !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL stall_consume got v=%0b imm=%h exp v=0 imm=fffffffc", id_valid, imm);
    end
  endtask

  task automatic test_illegal();
    drive(1, 32'h0000_0000, 32'h0000_0300, 1, 0);
    tick();
    total++; if ({id_valid, illegal, rd_we, mem_req, branch, jump} !== 6'b110000 || alu_opt !== ALU_NONE) begin
      bad++; $display("FAIL illegal_zero got v/ill/we/req/br/j=%b alu=%0d exp 110000 alu=%0d",
                      {id_valid, illegal, rd_we, mem_req, branch, jump}, alu_opt, ALU_NONE);
    end
  endtask

  task automatic test_flush();
    drive(1, 32'h0020_81B3, 32'h0000_0400, 1, 1);
    tick();
    total++; if (id_valid !== 1'b0 || illegal !== 1'b1 || pc_out !== 32'h300) begin
      bad++; $display("FAIL flush got v=%0b ill=%0b pc=%h exp v=0 ill=1 pc=00000300", id_valid, illegal, pc_out);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 32'hFFC3_A303, 32'h0000_0500, 1, 0);
    tick();
    drive(1, 32'h0020_81B3, 32'h0000_0504, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (id_valid !== 1'b0 || alu_opt !== ALU_NONE || mem_req !== 1'b0) begin
      bad++; $display("FAIL async_reset got v=%0b alu=%0d req=%0b exp 0 %0d 0", id_valid, alu_opt, mem_req, ALU_NONE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h4020_81B3, 32'h0000_0600, 1, 0);
    tick();
    total++; if (id_valid !== 1'b1 || alu_opt !== ALU_SUB || rd !== 5'd3 || pc_out !== 32'h600) begin
      bad++; $display("FAIL post_reset got v=%0b alu=%0d rd=%0d pc=%h exp 1 %0d 3 00000600",
                      id_valid, alu_opt, rd, pc_out, ALU_SUB);
    end
  endtask

  task automatic test_random();
    logic [6:0]  opcs [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [31:0] ins;
    ref_t        got;
    bit          v, exr, fl;
    for (int i = 0; i < 600; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[6:0] = opcs[$urandom_range(0, 10)];
      if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
        ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      v   = ($urandom_range(0, 3) != 0);
      exr = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      drive(v, ins, $urandom, exr, fl);
      #1;
      total++; if (instr_ready !== (!m_valid || exr)) begin
        bad++; $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", i, instr_ready, !m_valid || exr);
      end
      tick();
      total++; if (id_valid !== m_valid || pc_out !== m_pc) begin
        bad++; $display("FAIL rnd_slot[%0d] got v=%0b pc=%h exp v=%0b pc=%h", i, id_valid, pc_out, m_valid, m_pc);
      end
      got = '{alu: alu_opt, a: op_a_sel, b: op_b_sel, rs1: rs1, rs2: rs2, rd: rd, rd_we: rd_we,
              imm: imm, mem_req: mem_req, mem_we: mem_we, mem_size: mem_size, mem_uns: mem_uns,
              branch: branch, jump: jump, bcond: bcond, illegal: illegal};
      total++; if (got !== m) begin
        bad++; $display("FAIL rnd_decode[%0d] instr=%h got=%h exp=%h", i, instr, got, m);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 0; instr_valid = 0; ex_ready = 0; instr = '0; pc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_add();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
